// File: rtl/uart_tx_sb_ctrl.sv
// uart_tx_sb_ctrl: memory-mapped UART transmitter on the core system bus.
// Software writes a byte to the data register, polls busy, and sets the bit
// divider, even parity and the stop-bit count. Frames use the configuration
// captured when they start and cannot be changed once started.
module uart_tx_sb_ctrl #(
  parameter int unsigned DEFAULT_DIV = 1042,
  parameter int unsigned MIN_DIV     = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic        req_i,
  input  logic        WE_i,
  input  logic [31:0] WD_i,
  output logic [31:0] RD_o,
  output logic        tx_o
);

  localparam logic [31:0] ADDR_DATA   = 32'h0000_0000;
  localparam logic [31:0] ADDR_BUSY   = 32'h0000_0004;
  localparam logic [31:0] ADDR_DIV    = 32'h0000_0008;
  localparam logic [31:0] ADDR_PARITY = 32'h0000_000C;
  localparam logic [31:0] ADDR_STOP2  = 32'h0000_0010;
  localparam logic [31:0] ADDR_RST    = 32'h0000_0024;

  localparam logic [15:0] DEF_DIV_C = 16'(DEFAULT_DIV);
  localparam logic [15:0] MIN_DIV_C = 16'(MIN_DIV);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Even parity bit: makes the total number of ones in data+parity even.
  function automatic logic even_parity(input logic [7:0] d);
    even_parity = ^d;
  endfunction

  state_t      state_r, state_nxt_s;
  logic [15:0] cnt_r, cnt_nxt_s;
  logic [2:0]  bit_idx_r, bit_nxt_s;
  logic        tx_r, tx_nxt_s;
  logic [31:0] rd_r, rd_nxt_s;

  // Configuration registers as seen by software
  logic [15:0] div_r;
  logic        parity_en_r;
  logic        stop2_r;

  // Per-frame snapshot of data and configuration
  logic [7:0]  data_lat_r;
  logic [15:0] div_lat_r;
  logic        par_en_lat_r;
  logic        par_bit_r;
  logic        stop2_lat_r;

  logic wr_s, rd_s, busy_s, soft_rst_s, rst_all_s;
  logic bit_end_s, frame_done_s, start_s, cfg_wr_ok_s;

  assign wr_s        = req_i & WE_i;
  assign rd_s        = req_i & ~WE_i;
  assign busy_s      = (state_r != ST_IDLE);
  assign soft_rst_s  = wr_s & (addr_i == ADDR_RST) & (WD_i == 32'd1);
  assign rst_all_s   = rst_i | soft_rst_s;
  assign bit_end_s   = (cnt_r == (div_lat_r - 16'd1));
  // Last clock of the last stop bit: a new frame may start on this edge.
  assign frame_done_s = (state_r == ST_STOP) & bit_end_s &
                        (bit_idx_r == {2'b00, stop2_lat_r});
  assign start_s     = wr_s & (addr_i == ADDR_DATA) & (~busy_s | frame_done_s);
  assign cfg_wr_ok_s = wr_s & ~busy_s;

  assign RD_o = rd_r;
  assign tx_o = tx_r;

  // Next-state, bit-timing counter and serial line value for the frame FSM
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    bit_nxt_s   = bit_idx_r;
    tx_nxt_s    = tx_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = ST_START;
          cnt_nxt_s   = 16'd0;
          bit_nxt_s   = 3'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_nxt_s = ST_DATA;
          cnt_nxt_s   = 16'd0;
          bit_nxt_s   = 3'd0;
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_nxt_s = 16'd0;
          if (bit_idx_r == 3'd7) begin
            bit_nxt_s   = 3'd0;
            state_nxt_s = par_en_lat_r ? ST_PARITY : ST_STOP;
          end else begin
            bit_nxt_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_nxt_s = ST_STOP;
          cnt_nxt_s   = 16'd0;
          bit_nxt_s   = 3'd0;
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          cnt_nxt_s = 16'd0;
          if (frame_done_s) begin
            bit_nxt_s   = 3'd0;
            state_nxt_s = start_s ? ST_START : ST_IDLE;
          end else begin
            bit_nxt_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 16'd0;
        bit_nxt_s   = 3'd0;
      end
    endcase

    case (state_nxt_s)
      ST_IDLE:   tx_nxt_s = 1'b1;
      ST_START:  tx_nxt_s = 1'b0;
      ST_DATA:   tx_nxt_s = data_lat_r[bit_nxt_s];
      ST_PARITY: tx_nxt_s = par_bit_r;
      ST_STOP:   tx_nxt_s = 1'b1;
      default:   tx_nxt_s = 1'b1;
    endcase
  end

  // Frame FSM state, counter and registered serial line
  always_ff @(posedge clk_i) begin
    if (rst_all_s) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 16'd0;
      bit_idx_r <= 3'd0;
      tx_r      <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      bit_idx_r <= bit_nxt_s;
      tx_r      <= tx_nxt_s;
    end
  end

  // Snapshot the byte and configuration when a frame is accepted
  always_ff @(posedge clk_i) begin
    if (rst_all_s) begin
      data_lat_r   <= 8'd0;
      div_lat_r    <= DEF_DIV_C;
      par_en_lat_r <= 1'b0;
      par_bit_r    <= 1'b0;
      stop2_lat_r  <= 1'b0;
    end else if (start_s) begin
      data_lat_r   <= WD_i[7:0];
      div_lat_r    <= div_r;
      par_en_lat_r <= parity_en_r;
      par_bit_r    <= even_parity(WD_i[7:0]);
      stop2_lat_r  <= stop2_r;
    end else begin
      data_lat_r   <= data_lat_r;
      div_lat_r    <= div_lat_r;
      par_en_lat_r <= par_en_lat_r;
      par_bit_r    <= par_bit_r;
      stop2_lat_r  <= stop2_lat_r;
    end
  end

  // Software-visible configuration; writes only land while the line is idle
  always_ff @(posedge clk_i) begin
    if (rst_all_s) begin
      div_r       <= DEF_DIV_C;
      parity_en_r <= 1'b0;
      stop2_r     <= 1'b0;
    end else begin
      if (cfg_wr_ok_s && (addr_i == ADDR_DIV) && (WD_i[15:0] >= MIN_DIV_C)) begin
        div_r <= WD_i[15:0];
      end else begin
        div_r <= div_r;
      end
      if (cfg_wr_ok_s && (addr_i == ADDR_PARITY)) begin
        parity_en_r <= WD_i[0];
      end else begin
        parity_en_r <= parity_en_r;
      end
      if (cfg_wr_ok_s && (addr_i == ADDR_STOP2)) begin
        stop2_r <= WD_i[0];
      end else begin
        stop2_r <= stop2_r;
      end
    end
  end

  // Read data mux; the output holds its value between reads
  always_comb begin
    rd_nxt_s = rd_r;
    if (rd_s) begin
      case (addr_i)
        ADDR_DATA:   rd_nxt_s = 32'd0;
        ADDR_BUSY:   rd_nxt_s = {31'd0, busy_s};
        ADDR_DIV:    rd_nxt_s = {16'd0, div_r};
        ADDR_PARITY: rd_nxt_s = {31'd0, parity_en_r};
        ADDR_STOP2:  rd_nxt_s = {31'd0, stop2_r};
        ADDR_RST:    rd_nxt_s = 32'd0;
        default:     rd_nxt_s = 32'd0;
      endcase
    end else begin
      rd_nxt_s = rd_r;
    end
  end

  // Registered read data
  always_ff @(posedge clk_i) begin
    if (rst_all_s) begin
      rd_r <= 32'd0;
    end else begin
      rd_r <= rd_nxt_s;
    end
  end

endmodule
